fetch_cycle: RTL and testbench

//   Instruction fetch stage of the 16-bit pipeline, directly upstream of the decode stage.

---
 rtl/fetch_cycle.sv | 161 ++++++++++++++++
 tb/tb_fetch_cycle.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction fetch stage feeding decode.
//   Issues in-order fetches over a req/gnt/rvalid memory interface, tags each
//   issued address in an in-flight FIFO, and buffers the returned words in a
//   small prefetch queue whose head is presented to decode as {ir, pc}.
//   A redirect flushes everything and discards responses still in flight.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request and address (address = fetch PC)
//   imem_gnt                 memory accepted the request this cycle
//   imem_rvalid/imem_rdata   in-order response word
//   stall                    decode cannot accept the head this cycle
//   redirect/redirect_pc     restart fetching at redirect_pc
//   valid/ir/pc              instruction presented to decode
module fetch_cycle #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned PC_INC    = 2,
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        valid,
    output logic [15:0] ir,
    output logic [15:0] pc
);
    localparam int unsigned XLEN  = 16;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fq_entry_t;

    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    fq_entry_t        fq_q [DEPTH];
    fq_entry_t        fq_d [DEPTH];
    logic [PTR_W-1:0] fq_head_q, fq_head_d, fq_tail_q, fq_tail_d;
    logic [CNT_W-1:0] fq_cnt_q, fq_cnt_d;
    logic [XLEN-1:0]  ifl_q [DEPTH];
    logic [XLEN-1:0]  ifl_d [DEPTH];
    logic [PTR_W-1:0] ifl_head_q, ifl_head_d, ifl_tail_q, ifl_tail_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic credit_ok;
    logic issue, resp, resp_keep, resp_drop, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request and decode-facing outputs, all taken from registered state.
    // Outstanding requests and buffered words share the DEPTH credits.
    always_comb begin
        credit_ok = (SUM_W'(outst_q) + SUM_W'(fq_cnt_q)) < SUM_W'(DEPTH);
        imem_req  = rst & credit_ok & ~redirect;
        imem_addr = fpc_q;
        valid     = (fq_cnt_q != '0);
        ir        = valid ? fq_q[fq_head_q].ir : NOP_INSTR;
        pc        = valid ? fq_q[fq_head_q].pc : last_pc_q;
    end

    // Next-state: issue, response capture/drop, decode pop, redirect flush.
    always_comb begin
        fpc_d      = fpc_q;
        last_pc_d  = pc;
        fq_d       = fq_q;
        fq_head_d  = fq_head_q;
        fq_tail_d  = fq_tail_q;
        fq_cnt_d   = fq_cnt_q;
        ifl_d      = ifl_q;
        ifl_head_d = ifl_head_q;
        ifl_tail_d = ifl_tail_q;
        outst_d    = outst_q;
        drop_d     = drop_q;

        issue     = imem_req & imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp      = imem_rvalid & (outst_q != '0);
        resp_keep = resp & (drop_q == '0);
        resp_drop = resp & (drop_q != '0);
        pop       = valid & ~stall;

        if (redirect) begin
            // Everything still in flight, including a response landing now, is stale.
            fpc_d      = redirect_pc;
            fq_head_d  = '0;
            fq_tail_d  = '0;
            fq_cnt_d   = '0;
            ifl_head_d = '0;
            ifl_tail_d = '0;
            outst_d    = outst_q - CNT_W'(resp);
            drop_d     = outst_d;
        end else begin
            if (issue) begin
                ifl_d[ifl_tail_q] = fpc_q;
                ifl_tail_d        = ptr_inc(ifl_tail_q);
                fpc_d             = fpc_q + XLEN'(PC_INC);
            end
            if (resp_keep) begin
                fq_d[fq_tail_q] = '{pc: ifl_q[ifl_head_q], ir: imem_rdata};
                fq_tail_d       = ptr_inc(fq_tail_q);
                ifl_head_d      = ptr_inc(ifl_head_q);
            end
            if (pop) begin
                fq_head_d = ptr_inc(fq_head_q);
            end
            fq_cnt_d = fq_cnt_q + CNT_W'(resp_keep) - CNT_W'(pop);
            outst_d  = outst_q + CNT_W'(issue) - CNT_W'(resp);
            drop_d   = drop_q - CNT_W'(resp_drop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q      <= RESET_PC;
            last_pc_q  <= RESET_PC;
            fq_head_q  <= '0;
            fq_tail_q  <= '0;
            fq_cnt_q   <= '0;
            ifl_head_q <= '0;
            ifl_tail_q <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fq_q[i]  <= '0;
                ifl_q[i] <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            last_pc_q  <= last_pc_d;
            fq_q       <= fq_d;
            fq_head_q  <= fq_head_d;
            fq_tail_q  <= fq_tail_d;
            fq_cnt_q   <= fq_cnt_d;
            ifl_q      <= ifl_d;
            ifl_head_q <= ifl_head_d;
            ifl_tail_q <= ifl_tail_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Memory must never answer a request that was not issued.
    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst) imem_rvalid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_fetch_cycle.sv
`timescale 1ns/1ps
// Bench for fetch_cycle: directed vector table, hand-written corner sequences,
// and a randomized run checked against a queue-based reference model.
module tb_fetch_cycle;
    localparam int          DEPTH_I  = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP      = 16'h0000;
    localparam int          NVEC     = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        valid;
    logic [15:0] ir;
    logic [15:0] pc;

    fetch_cycle #(
        .RESET_PC (RESET_PC),
        .PC_INC   (2),
        .DEPTH    (2),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .valid      (valid),
        .ir         (ir),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [15:0] rdata;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
    } ent_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: fetch PC, decode queue, in-flight tags, counters.
    logic [15:0] m_fpc;
    logic [15:0] m_last_pc;
    ent_t        m_q[$];
    logic [15:0] m_infl[$];
    int          m_outst;
    int          m_drop;

    // Memory responder state.
    mreq_t mem_q[$];
    int    cyc;
    int    last_due;
    int    mem_k_lo;
    int    mem_k_hi;

    // Per-cycle samples for the directed sequences.
    logic        s_req, s_valid, last_issue;
    logic [15:0] s_addr, s_ir, s_pc;
    logic [15:0] seen_pc[$];

    vec_t tbl[NVEC];

    function automatic logic [15:0] memword(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic vec_t mk(input logic g, input logic rv, input logic [15:0] rd,
                                input logic s, input logic r, input logic [15:0] rpc,
                                input logic er, input logic [15:0] ea, input logic ev,
                                input logic [15:0] ei, input logic [15:0] ep);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.stall = s; v.redir = r; v.rpc = rpc;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_ir = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fpc     = RESET_PC;
        m_last_pc = RESET_PC;
        m_q.delete();
        m_infl.delete();
        m_outst   = 0;
        m_drop    = 0;
        mem_q.delete();
        last_due  = -1;
    endtask

    // One clock of the behavioural rules, given what happened on the interface.
    task automatic model_step(input logic iss, input logic rv, input logic [15:0] rdat,
                              input logic s, input logic rd, input logic [15:0] rpc);
        logic resp;
        ent_t e;
        resp = rv && (m_outst > 0);
        if (m_q.size() > 0) m_last_pc = m_q[0].pc;
        if (rd) begin
            m_q.delete();
            m_infl.delete();
            if (resp) m_outst--;
            m_drop = m_outst;
            m_fpc  = rpc;
        end else begin
            if (m_q.size() > 0 && !s) void'(m_q.pop_front());
            if (resp) begin
                m_outst--;
                if (m_drop > 0) m_drop--;
                else begin
                    e.pc = m_infl.pop_front();
                    e.ir = rdat;
                    m_q.push_back(e);
                end
            end
            if (iss) begin
                m_infl.push_back(m_fpc);
                m_fpc = m_fpc + 16'd2;
                m_outst++;
            end
        end
    endtask

    // Drive one cycle, compare every output with the model, then advance.
    task automatic cycle(input logic g, input logic s, input logic rd, input logic [15:0] rpc);
        logic        rv, e_req, e_valid;
        logic [15:0] rdat, e_ir, e_pc;
        int          due;
        rv   = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdat = 16'($urandom);
        if (rv) rdat = memword(mem_q[0].addr);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rdat;
        stall = s; redirect = rd; redirect_pc = rpc;
        #1;
        e_req   = ((m_outst + m_q.size()) < DEPTH_I) && !rd;
        e_valid = (m_q.size() > 0);
        e_ir    = NOP;
        e_pc    = m_last_pc;
        if (e_valid) begin
            e_ir = m_q[0].ir;
            e_pc = m_q[0].pc;
        end
        chk1 ("req",   imem_req,  e_req);
        chk16("addr",  imem_addr, m_fpc);
        chk1 ("valid", valid,     e_valid);
        chk16("ir",    ir,        e_ir);
        chk16("pc",    pc,        e_pc);
        s_req = imem_req; s_addr = imem_addr; s_valid = valid; s_ir = ir; s_pc = pc;
        if (valid && !s) seen_pc.push_back(pc);
        last_issue = imem_req && g;
        if (last_issue) begin
            due = cyc + $urandom_range(mem_k_hi, mem_k_lo);
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{addr: imem_addr, due: due});
            last_due = due;
        end
        if (rv) void'(mem_q.pop_front());
        model_step(e_req && g, rv, rdat, s, rd, rpc);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int grants;
        logic found;
        logic g, s, rd;
        logic [15:0] rpc;

        // gnt, rv, rdata, stall, redir, rpc | req, addr, valid, ir, pc
        tbl[0]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000);
        tbl[1]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000);
        tbl[2]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000);
        tbl[3]  = mk(1'b1,1'b1,16'h1111,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0000,16'h0000);
        tbl[4]  = mk(1'b1,1'b1,16'h2222,1'b1,1'b0,16'h0000, 1'b0,16'h0004,1'b1,16'h1111,16'h0000);
        tbl[5]  = mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,16'h0004,1'b1,16'h1111,16'h0000);
        tbl[6]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,16'h0004,1'b1,16'h1111,16'h0000);
        tbl[7]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0004,1'b1,16'h2222,16'h0002);
        tbl[8]  = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0004,1'b0,16'h0000,16'h0002);
        tbl[9]  = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0100, 1'b0,16'h0006,1'b0,16'h0000,16'h0002);
        tbl[10] = mk(1'b0,1'b1,16'hDEAD,1'b0,1'b0,16'h0000, 1'b1,16'h0100,1'b0,16'h0000,16'h0002);
        tbl[11] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0100,1'b0,16'h0000,16'h0002);
        tbl[12] = mk(1'b0,1'b1,16'hBEEF,1'b0,1'b0,16'h0000, 1'b1,16'h0102,1'b0,16'h0000,16'h0002);
        tbl[13] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0102,1'b1,16'hBEEF,16'h0100);
        tbl[14] = mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'hFFFE, 1'b0,16'h0102,1'b0,16'h0000,16'h0100);
        tbl[15] = mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'hFFFE,1'b0,16'h0000,16'h0100);
        tbl[16] = mk(1'b1,1'b1,16'h7777,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0100);
        tbl[17] = mk(1'b0,1'b1,16'h8888,1'b0,1'b0,16'h0000, 1'b0,16'h0002,1'b1,16'h7777,16'hFFFE);
        tbl[18] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b1,16'h8888,16'h0000);
        tbl[19] = mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0000,16'h0000);

        cyc = 0; mem_k_lo = 1; mem_k_hi = 1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b0;
        model_reset();
        #1;
        chk1 ("rst_req",   imem_req,  1'b0);
        chk16("rst_addr",  imem_addr, RESET_PC);
        chk1 ("rst_valid", valid,     1'b0);
        chk16("rst_ir",    ir,        NOP);
        chk16("rst_pc",    pc,        RESET_PC);
        @(negedge clk);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
            stall = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            #1;
            chk1 ($sformatf("tbl%0d_req", i),   imem_req,  tbl[i].e_req);
            chk16($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].e_addr);
            chk1 ($sformatf("tbl%0d_valid", i), valid,     tbl[i].e_valid);
            chk16($sformatf("tbl%0d_ir", i),    ir,        tbl[i].e_ir);
            chk16($sformatf("tbl%0d_pc", i),    pc,        tbl[i].e_pc);
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming with gnt always high and one-cycle memory.
        do_reset();
        mem_k_lo = 1; mem_k_hi = 1;
        seen_pc.delete();
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        chk1("t1_count", seen_pc.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < seen_pc.size(); i++)
            chk16($sformatf("t1_order%0d", i), seen_pc[i], 16'(2 * i));

        // Stall for five cycles: only the credits' worth of grants, head held.
        do_reset();
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            if (last_issue) grants++;
        end
        chk1 ("t2_grants",  grants == 2, 1'b1);
        chk1 ("t2_req_off", s_req, 1'b0);
        chk1 ("t2_valid",   s_valid, 1'b1);
        chk16("t2_pc_held", s_pc, 16'h0000);
        chk16("t2_ir_held", s_ir, memword(16'h0000));
        seen_pc.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        chk1("t2_count", seen_pc.size() >= 3, 1'b1);
        for (int i = 0; i < 3 && i < seen_pc.size(); i++)
            chk16($sformatf("t2_order%0d", i), seen_pc[i], 16'(2 * i));

        // Redirect with two slow requests outstanding: both must be dropped.
        do_reset();
        mem_k_lo = 4; mem_k_hi = 4;
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b1, 16'h0100);
        chk1("t3_req_redirect", s_req, 1'b0);
        mem_k_lo = 1; mem_k_hi = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            if (s_valid) found = 1'b1;
        end
        chk1("t3_valid_seen", found, 1'b1);
        chk16("t3_pc", s_pc, 16'h0100);
        chk16("t3_ir", s_ir, memword(16'h0100));

        // gnt held low: request and address stable, redirect withdraws it.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        chk1 ("t5_req_c1",  s_req, 1'b1);
        chk16("t5_addr_c1", s_addr, 16'h0002);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        chk1 ("t5_req_c2",  s_req, 1'b1);
        chk16("t5_addr_c2", s_addr, 16'h0002);
        cycle(1'b0, 1'b1, 1'b1, 16'h0200);
        chk1 ("t5_req_c3",  s_req, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        chk1 ("t5_req_c4",  s_req, 1'b1);
        chk16("t5_addr_c4", s_addr, 16'h0200);

        // Asynchronous reset mid-stream with requests in flight.
        do_reset();
        mem_k_lo = 2; mem_k_hi = 2;
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; stall = 1'b1; redirect = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk1 ("t6_req",   imem_req,  1'b0);
        chk16("t6_addr",  imem_addr, RESET_PC);
        chk1 ("t6_valid", valid,     1'b0);
        chk16("t6_ir",    ir,        NOP);
        chk16("t6_pc",    pc,        RESET_PC);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        chk1 ("t6_restart_req",  s_req, 1'b1);
        chk16("t6_restart_addr", s_addr, RESET_PC);

        // Randomized traffic against the reference model.
        do_reset();
        mem_k_lo = 1; mem_k_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            g   = ($urandom_range(99, 0) < 70);
            s   = ($urandom_range(99, 0) < 30);
            rd  = ($urandom_range(99, 0) < 4);
            rpc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(3, 0) == 0) rpc = 16'hFFFA;
            cycle(g, s, rd, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
